// File: rtl/core_pkg.sv
// Shared pipeline types and constants for the RV32I core.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: flush to bubble, hold on stall, or load a new fetch.
module ifid_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = core_pkg::NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  logic  hold,
  input  logic  load,
  input  ifid_t d,
  output ifid_t q
);

  // Bubble keeps pc/pc_plus4 so only instr and valid change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q.pc       <= '0;
      q.pc_plus4 <= '0;
      q.instr    <= NOP;
      q.valid    <= 1'b0;
    end else if (flush) begin
      q.instr <= NOP;
      q.valid <= 1'b0;
    end else if (!hold && load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, run/halt FSM, range check and fetch counter.
module if_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_DEPTH = 100,
  parameter logic [XLEN-1:0] NOP_INSTR  = core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic [XLEN-1:0] ifid_instr,
  output logic            ifid_valid,
  output logic            halted,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] count_q;
  logic            in_range;
  logic            flush, load, count_inc;
  ifid_t           ifid_d, ifid_q;

  assign imem_addr = {2'b00, pc_q[XLEN-1:2]};
  assign in_range  = pc_q[XLEN-1:2] < 30'(IMEM_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (count_inc) count_q <= count_q + 32'd1;
    end
  end

  // Redirect beats stall; HALT bubbles every cycle until redirected.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    flush     = 1'b0;
    load      = 1'b0;
    count_inc = 1'b0;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      flush   = 1'b1;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (!stall) begin
            if (in_range) begin
              load      = 1'b1;
              pc_d      = pc_q + 32'd4;
              count_inc = 1'b1;
            end else begin
              flush   = 1'b1;
              state_d = HALT;
            end
          end
        end
        HALT:    flush = 1'b1;
        default: state_d = RUN;
      endcase
    end
  end

  assign ifid_d = '{pc: pc_q, pc_plus4: pc_q + 32'd4, instr: imem_instr, valid: 1'b1};

  ifid_reg #(.NOP(NOP_INSTR)) u_ifid (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .hold  (stall),
    .load  (load),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_valid    = ifid_q.valid;
  assign halted        = (state_q == HALT);
  assign fetch_count   = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage against a behavioural fetch model.
module tb_if_stage;

  localparam int unsigned DEPTH = 100;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] count;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_instr;
  logic [31:0] ifid_pc, ifid_pc_plus4, ifid_instr, fetch_count;
  logic        ifid_valid, halted;

  logic [31:0] mem [DEPTH];
  logic [31:0] junk;
  exp_t        sb[$];
  int          vectors = 0;
  int          errors  = 0;
  bit          done    = 1'b0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_instr     (ifid_instr),
    .ifid_valid     (ifid_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  // Combinational instruction memory; out-of-range reads return garbage.
  always_comb imem_instr = (imem_addr < 32'(DEPTH)) ? mem[imem_addr[6:0]] : junk;

  // Reference model: apply the fetch rules to the sampled inputs each edge.
  logic [31:0] m_pc = 32'h0, m_ipc = 32'h0, m_ipc4 = 32'h0, m_instr = NOP, m_cnt = 32'h0;
  logic        m_valid = 1'b0, m_halt = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP;
      m_valid = 1'b0; m_halt = 1'b0; m_cnt = 32'h0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc & ~32'h3; m_instr = NOP; m_valid = 1'b0; m_halt = 1'b0;
    end else if (m_halt) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (!stall) begin
      if ((m_pc / 4) < DEPTH) begin
        m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = mem[m_pc / 4]; m_valid = 1'b1;
        m_pc = m_pc + 4; m_cnt = m_cnt + 1;
      end else begin
        m_instr = NOP; m_valid = 1'b0; m_halt = 1'b1;
      end
    end
    sb.push_back('{m_pc, m_ipc, m_ipc4, m_instr, m_valid, m_halt, m_cnt});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: compare every presented output on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!done && sb.size() > 0) begin
      e = sb.pop_front();
      chk("imem_addr", imem_addr, e.pc >> 2);
      chk("ifid_pc", ifid_pc, e.ifid_pc);
      chk("ifid_pc_plus4", ifid_pc_plus4, e.ifid_pc4);
      chk("ifid_instr", ifid_instr, e.ifid_instr);
      chk("ifid_valid", 32'(ifid_valid), 32'(e.ifid_valid));
      chk("halted", 32'(halted), 32'(e.halted));
      chk("fetch_count", fetch_count, e.count);
    end
  end

  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rp);
    rst_n = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    junk = $urandom;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
    mem[0] = 32'h39900313; mem[1] = 32'h00602223;
    mem[2] = 32'h00400283; mem[3] = 32'h00502023;
    junk = 32'hDEAD_BEEF;
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    step(0, 0, 0, 0); step(0, 1, 1, 32'h40);
    // Free run, stall at pc 8, redirect under stall, misaligned redirect
    repeat (2) step(1, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 1, 32'h34);
    repeat (2) step(1, 0, 0, 0);
    step(1, 0, 1, 32'h37);
    repeat (2) step(1, 0, 0, 0);
    // Run off the end of memory, sit halted (with stall), then redirect back
    step(1, 0, 1, 32'h170);
    repeat (12) step(1, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h8);
    repeat (8) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    // Random traffic, redirects biased toward the top of memory
    for (int n = 0; n < 3000; n++) begin
      logic r, s, rv;
      logic [31:0] rp;
      r  = ($urandom_range(0, 199) != 0);
      s  = ($urandom_range(0, 4) == 0);
      rv = ($urandom_range(0, 39) == 0);
      rp = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(80 * 4, 110 * 4));
      step(r, s, rv, rp);
    end
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined RV32I core.
- Holds the PC register and presents the word address to the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles hazard-unit stalls, branch/jump redirects (flush), and halting when the PC runs past the end of program memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_DEPTH, 100, number of 32-bit words in instruction memory; valid word indices are 0..IMEM_DEPTH-1.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- redirect_valid  input  1  branch/jump resolved taken this cycle.
- redirect_pc  input  32  byte address of the redirect target.
- imem_addr  output  32  word index to instruction memory (pc >> 2).
- imem_instr  input  32  instruction word read combinationally at imem_addr.
- ifid_pc  output  32  byte PC of the instruction in IF/ID.
- ifid_pc_plus4  output  32  ifid_pc + 4.
- ifid_instr  output  32  instruction in IF/ID.
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- halted  output  1  fetch stopped: PC is beyond IMEM_DEPTH.
- fetch_count  output  32  number of instructions latched into IF/ID with valid=1.

Behaviour:
- Single clock domain. Reset is synchronous and active-low. All state updates on the rising edge of clk.
- Reset (rst_n=0 at an edge), regardless of other inputs:
  - pc=RESET_PC, state=RUN.
  - ifid_pc=0, ifid_pc_plus4=0, ifid_instr=NOP_INSTR, ifid_valid=0.
  - halted=0, fetch_count=0.
  - Reset mid-operation discards everything in flight.
- imem_addr = {2'b00, pc[31:2]}, combinational from the PC register.
- in_range = (pc[31:2] < IMEM_DEPTH).
- Latency: the instruction at pc appears on ifid_instr exactly one cycle after pc drives imem_addr.
- FSM states: RUN, HALT. halted = (state==HALT).
- Per-edge priority, highest first: reset > redirect_valid > stall > normal.
- redirect_valid=1, in either state, with or without stall:
  - pc <= {redirect_pc[31:2], 2'b00}; misaligned low bits are silently dropped.
  - IF/ID <= bubble (NOP_INSTR, valid=0, ifid_pc/ifid_pc_plus4 unchanged).
  - state <= RUN. The new target's range is checked on the next cycle.
- stall=1, redirect_valid=0: pc, IF/ID, state and fetch_count all hold.
- RUN, no stall, no redirect, in_range=1:
  - IF/ID <= {pc, pc+4, imem_instr, valid=1}.
  - pc <= pc + 4, wrapping modulo 2^32.
  - fetch_count increments, wrapping modulo 2^32.
- RUN, no stall, no redirect, in_range=0:
  - IF/ID <= bubble; pc holds; state <= HALT.
  - imem_instr is ignored (out-of-range memory read is undefined).
- HALT, no redirect: pc holds, IF/ID <= bubble every cycle, regardless of stall.
- Only redirect_valid or reset leaves HALT.
- Bubble cycles never increment fetch_count.
- Width rules: PC arithmetic is 32-bit unsigned. The in_range compare uses the 30-bit word index against IMEM_DEPTH.

Decomposition:
- Shared package core_pkg: NOP_INSTR constant, XLEN=32, fetch_state_t enum {RUN, HALT}, and an ifid_t packed struct {pc, pc_plus4, instr, valid}.
- The ID stage imports ifid_t from the same package.
- One natural sub-module, ifid_reg: the IF/ID register with load, hold (stall) and flush (bubble) controls.
- if_stage contains the PC register, the FSM, the range check and the counter.

Test Plan:
- Reset then free-run, with memory words 0..3 = 0x39900313, 0x00602223, 0x00400283, 0x00502023 → cycles 1..4 show ifid_pc=0,4,8,12 with matching ifid_instr, valid=1; fetch_count=4.
- stall=1 for 3 cycles after pc=8 → imem_addr stays 2; IF/ID holds pc 4 / 0x00602223; fetch_count frozen; resumes with pc 8 when stall drops.
- redirect_valid=1, redirect_pc=0x34, asserted with stall=1 → next cycle pc=0x34, ifid_valid=0, ifid_instr=0x00000013; the following cycle ifid_pc=0x34.
- Run to pc=0x190 (word 100) with IMEM_DEPTH=100 → after ifid_pc=0x18C, one bubble, halted=1, pc stays 0x190; redirect to 0x8 clears halted and fetches word 2.
- redirect_pc=0x37 (misaligned) → pc=0x34, no other effect.
- rst_n=0 for one cycle mid-stream at pc=0x20 → next cycle pc=RESET_PC, ifid_valid=0, fetch_count=0, halted=0.
